// File: rtl/segment_dispatcher_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// segment_dispatcher_if : upstream word source, per-axis offer bus, status
// Rev 1.0
// ----------------------------------------------------------------------------
interface segment_dispatcher_if #(
  parameter int NumAxes   = 4,
  parameter int ReadBytes = 4
);
  logic                     enable;
  logic                     src_available;
  logic                     src_request;
  logic [8*ReadBytes-1:0]   src_data;
  logic [NumAxes-1:0]       axis_available;
  logic [NumAxes-1:0]       axis_request;
  logic [8*ReadBytes-1:0]   axis_data;
  logic [NumAxes-1:0]       axis_busy;
  logic [NumAxes-1:0]       dir_out;
  logic                     segment_active;
  logic                     segment_done;

  modport master (
    input  enable, src_available, src_data, axis_request, axis_busy,
    output src_request, axis_available, axis_data, dir_out, segment_active, segment_done
  );

  modport slave (
    output enable, src_available, src_data, axis_request, axis_busy,
    input  src_request, axis_available, axis_data, dir_out, segment_active, segment_done
  );
endinterface
`default_nettype wire

// File: rtl/segment_dispatcher.sv
`default_nettype none
// ----------------------------------------------------------------------------
// segment_dispatcher : splits header + count-word segments across step axes
// Rev 1.0
// ----------------------------------------------------------------------------
module segment_dispatcher #(
  parameter int NumAxes   = 4,
  parameter int ReadBytes = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  segment_dispatcher_if.master bus
);

  localparam int                 c_data_w   = 8 * ReadBytes;
  localparam int                 c_sel_w    = (NumAxes > 1) ? $clog2(NumAxes) : 1;
  localparam logic [NumAxes-1:0] c_axis_one = NumAxes'(1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SCAN      = 3'd1,
    FETCH     = 3'd2,
    OFFER     = 3'd3,
    WAIT_DONE = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [NumAxes-1:0]   mask_q,  mask_d;
  logic [NumAxes-1:0]   dir_q,   dir_d;
  logic [c_sel_w-1:0]   sel_q,   sel_d;
  logic [c_data_w-1:0]  data_q,  data_d;
  logic                 active_q, active_d;
  logic                 done_q,   done_d;

  logic [c_sel_w-1:0]   low_sel;
  logic                 low_hit;
  logic [NumAxes-1:0]   sel_onehot;
  logic                 src_req;

  // Lowest remaining axis: scan downwards so the last hit is the smallest index
  always_comb begin
    low_sel = '0;
    low_hit = 1'b0;
    for (int i = NumAxes - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        low_sel = c_sel_w'(i);
        low_hit = 1'b1;
      end
    end
  end

  assign sel_onehot = c_axis_one << sel_q;

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    dir_d    = dir_q;
    sel_d    = sel_q;
    data_d   = data_q;
    active_d = active_q;
    done_d   = 1'b0;
    src_req  = 1'b0;

    unique case (state_q)
      IDLE: begin
        // done_q high means the previous segment finished last edge; hold off one cycle
        if (bus.enable && bus.src_available && !done_q) begin
          src_req  = 1'b1;
          mask_d   = bus.src_data[NumAxes-1:0];
          dir_d    = bus.src_data[2*NumAxes-1:NumAxes];
          active_d = 1'b1;
          state_d  = SCAN;
        end
      end

      SCAN: begin
        if (low_hit) begin
          sel_d   = low_sel;
          state_d = FETCH;
        end else begin
          state_d = WAIT_DONE;
        end
      end

      FETCH: begin
        if (bus.src_available) begin
          src_req = 1'b1;
          data_d  = bus.src_data;
          state_d = OFFER;
        end
      end

      OFFER: begin
        if ((bus.axis_request & sel_onehot) != '0) begin
          mask_d  = mask_q & ~sel_onehot;
          state_d = SCAN;
        end
      end

      WAIT_DONE: begin
        if (bus.axis_busy == '0) begin
          done_d   = 1'b1;
          active_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      dir_q    <= '0;
      sel_q    <= '0;
      data_q   <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      dir_q    <= dir_d;
      sel_q    <= sel_d;
      data_q   <= data_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  // Request is gated by rst so nothing is consumed while reset is held
  assign bus.src_request    = src_req & ~rst;
  assign bus.axis_available = (state_q == OFFER) ? sel_onehot : '0;
  assign bus.axis_data      = data_q;
  assign bus.dir_out        = dir_q;
  assign bus.segment_active = active_q;
  assign bus.segment_done   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_segment_dispatcher.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_segment_dispatcher : scoreboard bench with randomized segments
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_segment_dispatcher;
  localparam int NA = 4;
  localparam int RB = 4;
  localparam int DW = 8 * RB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  segment_dispatcher_if #(.NumAxes(NA), .ReadBytes(RB)) bus ();
  segment_dispatcher #(.NumAxes(NA), .ReadBytes(RB)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int axis; logic [DW-1:0] data; logic [NA-1:0] dir; } acc_exp_t;
  typedef struct { logic [NA-1:0] dir; int n_acc; } done_exp_t;
  typedef logic [DW-1:0] cnt_arr_t [NA];

  logic [DW-1:0] src_q[$];
  acc_exp_t      exp_acc_q[$];
  done_exp_t     exp_done_q[$];

  int checks = 0;
  int errors = 0;

  int en_mode, acc_mode;
  bit spur, force_low, use_forced_req, avail_seen;
  logic [NA-1:0] forced_req;
  int busy_cnt [NA];
  int cyc, req_pulses, done_pulses, acc_pulses, hdr_cyc, done_cyc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference model: header word, then one count per set mask bit in ascending order
  task automatic push_segment(input logic [NA-1:0] mask, input logic [NA-1:0] dir, input cnt_arr_t c);
    logic [DW-1:0] hdr;
    acc_exp_t      e;
    done_exp_t     d;
    int            n;
    hdr = $urandom;
    hdr[NA-1:0]      = mask;
    hdr[2*NA-1:NA]   = dir;
    src_q.push_back(hdr);
    n = 0;
    for (int i = 0; i < NA; i++) begin
      if (mask[i]) begin
        src_q.push_back(c[i]);
        e.axis = i; e.data = c[i]; e.dir = dir;
        exp_acc_q.push_back(e);
        n++;
      end
    end
    d.dir = dir; d.n_acc = n;
    exp_done_q.push_back(d);
  endtask

  task automatic drive();
    logic [NA-1:0] busy, req;
    for (int i = 0; i < NA; i++) begin
      if (busy_cnt[i] > 0) busy_cnt[i]--;
      busy[i] = (busy_cnt[i] > 0);
    end
    bus.axis_busy = busy;
    case (en_mode)
      0:       bus.enable = 1'b0;
      1:       bus.enable = 1'b1;
      default: bus.enable = ($urandom_range(0, 7) != 0);
    endcase
    if (!force_low && src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      bus.src_available = 1'b1;
      bus.src_data      = src_q[0];
    end else begin
      bus.src_available = 1'b0;
      bus.src_data      = $urandom;
    end
    req = '0;
    if (use_forced_req) begin
      req = forced_req;
    end else begin
      if (spur) req = NA'($urandom) & ~bus.axis_available;
      if (bus.axis_available != '0 &&
          (acc_mode == 1 || (acc_mode == 2 && $urandom_range(0, 1) == 1)))
        req = req | bus.axis_available;
    end
    bus.axis_request = req;
  endtask

  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (bus.src_request) begin
      req_pulses++;
      if (!bus.segment_active) hdr_cyc = cyc;
      if (bus.src_available && src_q.size() > 0) void'(src_q.pop_front());
    end
    if (bus.segment_done) begin
      done_pulses++;
      done_cyc = cyc;
    end
    if (bus.axis_available != '0) avail_seen = 1'b1;
    for (int i = 0; i < NA; i++) begin
      if (bus.axis_available[i] && bus.axis_request[i]) begin
        acc_pulses++;
        busy_cnt[i] = $urandom_range(2, 7);
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src_q.size() > 0 || exp_acc_q.size() > 0 || exp_done_q.size() > 0 ||
            bus.segment_active) && n < budget) begin
      cycle();
      n++;
    end
    check("drain_within_budget", (n < budget), 1);
    repeat (3) cycle();
  endtask

  // Monitor: pops expectations whenever the DUT hands over a word or finishes a segment
  initial begin : monitor
    logic          skip, prev_req, prev_hdr;
    logic [NA-1:0] prev_avail, prev_dir, prev_busy;
    logic [DW-1:0] prev_data;
    int            in_seg_acc;
    acc_exp_t      e;
    done_exp_t     d;
    skip = 1'b1; prev_req = 1'b0; prev_hdr = 1'b0; prev_avail = '0;
    prev_dir = '0; prev_busy = '0; prev_data = '0; in_seg_acc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        skip = 1'b1;
        in_seg_acc = 0;
      end else if (skip) begin
        skip = 1'b0;
      end else begin
        if (bus.src_request) begin
          check("req_needs_avail", bus.src_available, 1);
          check("req_back_to_back", prev_req, 0);
          if (!bus.segment_active) begin
            check("hdr_needs_enable", bus.enable, 1);
            check("hdr_same_cycle_as_done", bus.segment_done, 0);
          end
        end
        if (bus.axis_available != '0) begin
          check("avail_onehot", $onehot(bus.axis_available), 1);
          if (prev_avail != '0) begin
            check("avail_held", bus.axis_available, prev_avail);
            check("avail_data_stable", bus.axis_data, prev_data);
          end
        end
        if (bus.dir_out != prev_dir) check("dir_change_only_on_header", prev_hdr, 1);
        for (int i = 0; i < NA; i++) begin
          if (bus.axis_available[i] && bus.axis_request[i]) begin
            if (exp_acc_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL accept_unexpected: axis %0d took 0x%0h, model expects none", i, bus.axis_data);
            end else begin
              e = exp_acc_q.pop_front();
              check("accept_axis", i, e.axis);
              check("accept_data", bus.axis_data, e.data);
              check("accept_dir", bus.dir_out, e.dir);
              in_seg_acc++;
            end
          end
        end
        if (bus.segment_done) begin
          check("done_after_busy_clear", prev_busy, 0);
          if (exp_done_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: segment_done seen, model expects none");
          end else begin
            d = exp_done_q.pop_front();
            check("done_dir", bus.dir_out, d.dir);
            check("done_accept_count", in_seg_acc, d.n_acc);
          end
          in_seg_acc = 0;
        end
      end
      prev_req   = bus.src_request;
      prev_hdr   = bus.src_request && !bus.segment_active;
      prev_avail = bus.axis_available;
      prev_data  = bus.axis_data;
      prev_dir   = bus.dir_out;
      prev_busy  = bus.axis_busy;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    cnt_arr_t      c;
    int            n;
    logic [NA-1:0] m, dr;

    en_mode = 1; acc_mode = 1; spur = 0; force_low = 0; use_forced_req = 0;
    forced_req = '0; avail_seen = 0;
    cyc = 0; req_pulses = 0; done_pulses = 0; acc_pulses = 0; hdr_cyc = -1; done_cyc = -1;
    for (int i = 0; i < NA; i++) busy_cnt[i] = 0;

    // Reset held with a word on offer: nothing may be consumed
    rst = 1'b1;
    bus.enable = 1'b1; bus.src_available = 1'b1; bus.src_data = 32'h0000_00FF;
    bus.axis_request = '1; bus.axis_busy = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_src_request", bus.src_request, 0);
    check("rst_axis_available", bus.axis_available, 0);
    check("rst_segment_active", bus.segment_active, 0);
    check("rst_segment_done", bus.segment_done, 0);
    check("rst_dir_out", bus.dir_out, 0);
    check("rst_axis_data", bus.axis_data, 0);
    @(posedge clk); #1;
    rst = 1'b0; bus.enable = 1'b0; bus.src_available = 1'b0; bus.axis_request = '0;

    // Two-axis segment: axis0 gets 10, axis2 gets 20
    c = '{32'd10, 32'd0, 32'd20, 32'd0};
    push_segment(4'b0101, 4'b0001, c);
    drain(200);
    check("basic_src_pulses", req_pulses, 3);
    check("basic_done_pulses", done_pulses, 1);
    check("basic_dir_held", bus.dir_out, 4'b0001);

    // Empty mask: header only, done three cycles after accept
    req_pulses = 0; done_pulses = 0; acc_pulses = 0; avail_seen = 0; hdr_cyc = -1; done_cyc = -1;
    push_segment(4'b0000, 4'b1010, c);
    drain(200);
    check("nomask_src_pulses", req_pulses, 1);
    check("nomask_done_pulses", done_pulses, 1);
    check("nomask_done_latency", done_cyc - hdr_cyc, 3);
    check("nomask_never_offered", avail_seen, 0);
    check("nomask_dir", bus.dir_out, 4'b1010);

    // Upstream stalls for 5 cycles while a count word is pending
    c = '{32'd0, 32'd0, 32'd0, 32'd77};
    push_segment(4'b1000, 4'b0110, c);
    n = 0;
    while (!bus.segment_active && n < 50) begin cycle(); n++; end
    check("stall_header_taken", bus.segment_active, 1);
    force_low = 1; bus.src_available = 1'b0; bus.src_data = $urandom;
    repeat (5) begin
      cycle();
      check("stall_no_request", bus.src_request, 0);
      check("stall_no_offer", bus.axis_available, 0);
    end
    check("stall_word_pending", src_q.size(), 1);
    force_low = 0;
    drain(200);

    // Request on axis1 while axis3 is offered must be ignored
    c = '{32'd0, 32'd0, 32'd0, 32'h0000_ABCD};
    acc_mode = 0;
    push_segment(4'b1000, 4'b0011, c);
    n = 0;
    while (bus.axis_available == '0 && n < 50) begin cycle(); n++; end
    check("ignore_offer_axis3", bus.axis_available, 4'b1000);
    use_forced_req = 1; forced_req = 4'b0010; bus.axis_request = forced_req;
    repeat (4) begin
      cycle();
      check("ignore_offer_held", bus.axis_available, 4'b1000);
      check("ignore_data_held", bus.axis_data, 32'h0000_ABCD);
    end
    use_forced_req = 0; acc_mode = 1;
    drain(200);

    // Randomized segments with enable dips, random acceptance and stray requests
    en_mode = 2; acc_mode = 2; spur = 1; done_pulses = 0;
    for (int s = 0; s < 30; s++) begin
      m  = NA'($urandom);
      dr = NA'($urandom);
      for (int i = 0; i < NA; i++) c[i] = $urandom;
      push_segment(m, dr, c);
    end
    drain(6000);
    check("random_done_pulses", done_pulses, 30);

    // Reset while an offer is outstanding, then a fresh segment
    en_mode = 1; acc_mode = 0; spur = 0;
    c = '{32'd0, 32'h1234_5678, 32'd0, 32'd0};
    push_segment(4'b0010, 4'b1111, c);
    n = 0;
    while (bus.axis_available == '0 && n < 50) begin cycle(); n++; end
    check("midrst_offer_axis1", bus.axis_available, 4'b0010);
    rst = 1'b1; bus.enable = 1'b0; bus.src_available = 1'b0; bus.axis_request = '0;
    @(posedge clk); #1;
    src_q.delete(); exp_acc_q.delete(); exp_done_q.delete();
    for (int i = 0; i < NA; i++) busy_cnt[i] = 0;
    bus.axis_busy = '0;
    @(negedge clk);
    check("midrst_src_request", bus.src_request, 0);
    check("midrst_axis_available", bus.axis_available, 0);
    check("midrst_segment_active", bus.segment_active, 0);
    check("midrst_segment_done", bus.segment_done, 0);
    check("midrst_dir_out", bus.dir_out, 0);
    check("midrst_axis_data", bus.axis_data, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    acc_mode = 1; req_pulses = 0; done_pulses = 0;
    c = '{32'd10, 32'd0, 32'd20, 32'd0};
    push_segment(4'b0101, 4'b0001, c);
    drive();
    drain(200);
    check("postrst_src_pulses", req_pulses, 3);
    check("postrst_done_pulses", done_pulses, 1);

    // enable low blocks headers; dropping it mid-segment does not abort
    en_mode = 0; req_pulses = 0; done_pulses = 0; acc_pulses = 0;
    c = '{32'd5, 32'd6, 32'd0, 32'd0};
    push_segment(4'b0001, 4'b0101, c);
    push_segment(4'b0010, 4'b1010, c);
    repeat (10) cycle();
    check("enlow_no_consume", req_pulses, 0);
    check("enlow_words_pending", src_q.size(), 4);
    en_mode = 1;
    n = 0;
    while (acc_pulses == 0 && n < 100) begin cycle(); n++; end
    en_mode = 0; bus.enable = 1'b0;
    repeat (30) cycle();
    check("endrop_first_done", done_pulses, 1);
    check("endrop_src_pulses", req_pulses, 2);
    check("endrop_second_pending", src_q.size(), 2);
    check("endrop_dir_held", bus.dir_out, 4'b0101);
    en_mode = 1;
    drain(300);
    check("endrop_second_done", done_pulses, 2);
    check("endrop_second_dir", bus.dir_out, 4'b1010);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
